// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and helpers for the HD44780 8-bit bus driver.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_ENTRY     = 8'h06;
  localparam logic [7:0] CMD_HOME      = 8'h02;
  localparam logic [7:0] CMD_DDRAM     = 8'h80;
  localparam logic [7:0] ROW1_BASE     = 8'h40;

  localparam int INIT_LEN = 6;

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT,
    IDLE,
    ADDR,
    DATA,
    DONE
  } lcd_state_t;

  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_SETUP,
    BUS_E_HIGH,
    BUS_EXEC
  } bus_state_t;

  // A timing parameter of 0 would underflow the load value, so it is run as 1.
  function automatic int at_least_one(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int cnt_width(input int t_pwr, input int t_clear);
    int m;
    m = at_least_one((t_pwr > t_clear) ? t_pwr : t_clear);
    return $clog2(m + 1);
  endfunction

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    logic [7:0] c;
    case (idx)
      3'd0, 3'd1, 3'd2: c = CMD_FUNC_8B2L;
      3'd3:             c = CMD_DISP_ON;
      3'd4:             c = CMD_CLEAR;
      default:          c = CMD_ENTRY;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// One HD44780 write cycle: SETUP (E low), E_HIGH, then EXEC wait; RS/DB held from the latch.
module lcd_bus_cycle
  import lcd_pkg::*;
#(
  parameter int T_PWR   = 750000,
  parameter int T_SETUP = 2,
  parameter int T_EPW   = 25,
  parameter int T_EXEC  = 2000,
  parameter int T_CLEAR = 82000
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       rs_clear,
  output logic       busy,
  output logic       done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [7:0] lcd_db
);

  localparam int CW = cnt_width(T_PWR, T_CLEAR);
  localparam logic [CW-1:0] LD_SETUP = CW'(at_least_one(T_SETUP) - 1);
  localparam logic [CW-1:0] LD_EPW   = CW'(at_least_one(T_EPW) - 1);
  localparam logic [CW-1:0] LD_EXEC  = CW'(at_least_one(T_EXEC) - 1);
  localparam logic [CW-1:0] LD_CLEAR = CW'(at_least_one(T_CLEAR) - 1);

  bus_state_t    st;
  logic [CW-1:0] cnt;
  logic          long_exec;

  assign long_exec = !lcd_rs && (lcd_db == CMD_CLEAR || lcd_db == CMD_HOME);
  assign busy      = (st != BUS_IDLE);
  // Asserted in the last EXEC cycle so the caller can chain the next byte without a gap.
  assign done      = (st == BUS_EXEC) && (cnt == '0);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      st     <= BUS_IDLE;
      cnt    <= '0;
      lcd_e  <= 1'b0;
      lcd_rs <= 1'b0;
      lcd_db <= 8'h00;
    end else begin
      case (st)
        BUS_IDLE: begin
          if (start) begin
            lcd_rs <= rs;
            lcd_db <= data;
            cnt    <= LD_SETUP;
            st     <= BUS_SETUP;
          end else if (rs_clear) begin
            lcd_rs <= 1'b0;
          end
        end
        BUS_SETUP: begin
          if (cnt == '0) begin
            lcd_e <= 1'b1;
            cnt   <= LD_EPW;
            st    <= BUS_E_HIGH;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        BUS_E_HIGH: begin
          if (cnt == '0) begin
            lcd_e <= 1'b0;
            cnt   <= long_exec ? LD_CLEAR : LD_EXEC;
            st    <= BUS_EXEC;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        BUS_EXEC: begin
          if (cnt == '0) begin
            if (start) begin
              lcd_rs <= rs;
              lcd_db <= data;
              cnt    <= LD_SETUP;
              st     <= BUS_SETUP;
            end else begin
              st <= BUS_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: st <= BUS_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lcd_hd44780_driver.sv
// HD44780 8-bit physical-bus stage: power-up wait, init table, row address insertion,
// per-character writes with a one-cycle Lista acknowledge back to the row-register stage.
//
//   state    | meaning
//   PWR_WAIT | counting T_PWR cycles after reset
//   INIT     | issuing the six-command init table
//   IDLE     | waiting for Escribir; RS pulled low when upstream is idle
//   ADDR     | row-address command on the bus
//   DATA     | character byte on the bus
//   DONE     | Lista pulse, RS kept high
module lcd_hd44780_driver
  import lcd_pkg::*;
#(
  parameter int T_PWR   = 750000,
  parameter int T_SETUP = 2,
  parameter int T_EPW   = 25,
  parameter int T_EXEC  = 2000,
  parameter int T_CLEAR = 82000
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       Escribir,
  input  logic [7:0] Dato_E_LCD,
  input  logic       Fila,
  output logic       Lista,
  output logic       Listo_Init,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic [7:0] LCD_DB
);

  localparam int PWR = at_least_one(T_PWR);
  localparam int PW  = $clog2(PWR + 1);

  lcd_state_t    state;
  logic [PW-1:0] pwr_cnt;
  logic [2:0]    init_idx;
  logic          nueva_fila;

  logic       bus_start;
  logic       bus_rs;
  logic [7:0] bus_data;
  logic       bus_rs_clear;
  logic       bus_busy;
  logic       bus_done;

  always_comb begin
    bus_start    = 1'b0;
    bus_rs       = 1'b0;
    bus_data     = 8'h00;
    bus_rs_clear = 1'b0;
    case (state)
      INIT: begin
        if (!bus_busy) begin
          bus_start = 1'b1;
          bus_data  = init_cmd(init_idx);
        end
      end
      IDLE: begin
        if (Escribir) begin
          bus_start = 1'b1;
          if (nueva_fila) begin
            bus_data = CMD_DDRAM | (Fila ? ROW1_BASE : 8'h00);
          end else begin
            bus_rs   = 1'b1;
            bus_data = Dato_E_LCD;
          end
        end else begin
          bus_rs_clear = 1'b1;
        end
      end
      ADDR: begin
        // Character byte follows the address back-to-back.
        if (bus_done) begin
          bus_start = 1'b1;
          bus_rs    = 1'b1;
          bus_data  = Dato_E_LCD;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= PWR_WAIT;
      pwr_cnt    <= '0;
      init_idx   <= 3'd0;
      nueva_fila <= 1'b0;
      Listo_Init <= 1'b0;
      Lista      <= 1'b0;
    end else begin
      Lista <= 1'b0;
      case (state)
        PWR_WAIT: begin
          if (pwr_cnt == PW'(PWR - 1)) begin
            pwr_cnt <= '0;
            state   <= INIT;
          end else begin
            pwr_cnt <= pwr_cnt + 1'b1;
          end
        end
        INIT: begin
          if (bus_done) begin
            if (init_idx == 3'(INIT_LEN - 1)) begin
              Listo_Init <= 1'b1;
              nueva_fila <= 1'b1;
              state      <= IDLE;
            end else begin
              init_idx <= init_idx + 1'b1;
            end
          end
        end
        IDLE: begin
          if (Escribir) begin
            state <= nueva_fila ? ADDR : DATA;
          end else begin
            nueva_fila <= 1'b1;
          end
        end
        ADDR: begin
          if (bus_done) begin
            nueva_fila <= 1'b0;
            state      <= DATA;
          end
        end
        DATA: begin
          if (bus_done) begin
            Lista <= 1'b1;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= PWR_WAIT;
      endcase
    end
  end

  lcd_bus_cycle #(
    .T_PWR  (T_PWR),
    .T_SETUP(T_SETUP),
    .T_EPW  (T_EPW),
    .T_EXEC (T_EXEC),
    .T_CLEAR(T_CLEAR)
  ) u_bus (
    .CLK     (CLK),
    .Reset   (Reset),
    .start   (bus_start),
    .rs      (bus_rs),
    .data    (bus_data),
    .rs_clear(bus_rs_clear),
    .busy    (bus_busy),
    .done    (bus_done),
    .lcd_e   (LCD_E),
    .lcd_rs  (LCD_RS),
    .lcd_db  (LCD_DB)
  );

  assign LCD_RW = 1'b0;

endmodule

// File: tb/tb_lcd_hd44780_driver.sv
// Bench for lcd_hd44780_driver: bus writes are captured on each E rise and compared with
// the byte sequence an HD44780 should receive; timing is checked against the parameter formulas.
module tb_lcd_hd44780_driver;

  localparam int T_PWR   = 10;
  localparam int T_SETUP = 1;
  localparam int T_EPW   = 3;
  localparam int T_EXEC  = 5;
  localparam int T_CLEAR = 20;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic       Escribir = 1'b0;
  logic       Fila = 1'b0;
  logic [7:0] Dato = 8'h00;
  logic       Lista, Listo_Init, LCD_RS, LCD_RW, LCD_E;
  logic [7:0] LCD_DB;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  lcd_hd44780_driver #(
    .T_PWR(T_PWR), .T_SETUP(T_SETUP), .T_EPW(T_EPW), .T_EXEC(T_EXEC), .T_CLEAR(T_CLEAR)
  ) dut (
    .CLK(CLK), .Reset(Reset), .Escribir(Escribir), .Dato_E_LCD(Dato), .Fila(Fila),
    .Lista(Lista), .Listo_Init(Listo_Init), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
    .LCD_E(LCD_E), .LCD_DB(LCD_DB)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: every write the panel would latch, {rs, db}, with the cycle E rose.
  logic [8:0] wr_q[$];
  int         wr_t[$];
  int         lista_n = 0, listo_t = 0, ehigh = 0;
  logic       e_prev = 1'b0, listo_prev = 1'b0, abort = 1'b0;
  logic [8:0] held = '0, prev_bus = '0;

  always @(negedge CLK) begin
    if (Reset && LCD_E) abort = 1'b1;
    if (LCD_E && !e_prev) begin
      check("setup_stable", prev_bus, {LCD_RS, LCD_DB});
      held = {LCD_RS, LCD_DB};
      wr_q.push_back(held);
      wr_t.push_back(cyc);
      ehigh = 1;
    end else if (LCD_E && e_prev) begin
      check("hold_stable", {LCD_RS, LCD_DB}, held);
      ehigh++;
    end
    if (!LCD_E && e_prev) begin
      if (!abort) check("e_width", ehigh, T_EPW);
      abort = 1'b0;
    end
    if (Lista) lista_n++;
    if (Listo_Init && !listo_prev) listo_t = cyc;
    listo_prev = Listo_Init;
    e_prev     = LCD_E;
    prev_bus   = {LCD_RS, LCD_DB};
  end

  logic [8:0] init_seq [6] = '{9'h038, 9'h038, 9'h038, 9'h00C, 9'h001, 9'h006};
  logic [8:0] exp_q[$];
  int         rel_t = 0;

  task automatic push_init();
    for (int i = 0; i < 6; i++) exp_q.push_back(init_seq[i]);
  endtask

  function automatic logic [8:0] addr_of(input logic f);
    return {1'b0, 8'h80 | (f ? 8'h40 : 8'h00)};
  endfunction

  task automatic compare_writes(input string tag);
    check({tag, "_count"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), wr_q[i], exp_q[i]);
    exp_q.delete();
  endtask

  task automatic sync_clear();
    @(posedge CLK); #1;
    wr_q.delete();
    wr_t.delete();
    lista_n = 0;
  endtask

  task automatic apply_reset(input logic esc);
    Reset = 1'b1;
    Escribir = esc;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_lista", Lista, 0);
    check("rst_listo", Listo_Init, 0);
    check("rst_rs", LCD_RS, 0);
    check("rst_rw", LCD_RW, 0);
    check("rst_e", LCD_E, 0);
    check("rst_db", LCD_DB, 0);
    @(posedge CLK); #1;
    Reset = 1'b0;
    wr_q.delete();
    wr_t.delete();
    lista_n = 0;
    rel_t = cyc;
  endtask

  task automatic wait_listo();
    int n = 0;
    while (!Listo_Init && n < 600) begin
      @(negedge CLK);
      n++;
    end
    if (!Listo_Init) check("listo_timeout", 0, 1);
  endtask

  task automatic wait_lista(output int t);
    int n = 0;
    t = -1;
    while (n < 300) begin
      @(negedge CLK);
      n++;
      if (Lista) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check("lista_timeout", 0, 1);
  endtask

  task automatic wait_data_e(output int t);
    int n = 0;
    t = -1;
    while (n < 300) begin
      @(negedge CLK);
      n++;
      if (LCD_E && LCD_RS) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check("data_e_timeout", 0, 1);
  endtask

  initial begin
    int t, t_r, prev_t, n;
    logic f, f2;
    logic [7:0] chars [20];
    logic [7:0] d2;

    // Power-up and init with upstream idle
    apply_reset(1'b0);
    wait_listo();
    repeat (3) @(posedge CLK); #1;
    if (wr_t.size() == 6) begin
      check("pwr_wait", (wr_t[0] - rel_t) >= T_PWR, 1);
      check("gap_cmd", ((wr_t[1] - wr_t[0]) >= T_EPW + T_EXEC) &&
                       ((wr_t[1] - wr_t[0]) < T_EPW + T_CLEAR), 1);
      check("gap_clear", (wr_t[5] - wr_t[4]) >= T_EPW + T_CLEAR, 1);
      check("listo_after_exec", (listo_t - wr_t[5]) >= T_EPW + T_EXEC, 1);
    end
    check("lista_in_init", lista_n, 0);
    push_init();
    compare_writes("init");
    sync_clear();

    // Single character on row 0
    @(negedge CLK);
    Fila = 1'b0; Dato = 8'h41; Escribir = 1'b1;
    wait_lista(t);
    Escribir = 1'b0;
    repeat (3) @(negedge CLK);
    check("rs_idle", LCD_RS, 0);
    if (wr_t.size() == 2) check("lista_latency", t - wr_t[1], T_EPW + T_EXEC);
    @(posedge CLK); #1;
    check("lista_count_1", lista_n, 1);
    exp_q.push_back(9'h080);
    exp_q.push_back(9'h141);
    compare_writes("char");
    sync_clear();

    // Full rows: first the fixed 20-char row on row 1, then random rows
    for (int r = 0; r < 3; r++) begin
      n = (r == 0) ? 20 : int'($urandom_range(1, 20));
      f = (r == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int k = 0; k < n; k++) chars[k] = (r == 0) ? 8'(8'h30 + k) : 8'($urandom_range(0, 255));
      exp_q.push_back(addr_of(f));
      for (int k = 0; k < n; k++) exp_q.push_back({1'b1, chars[k]});
      @(negedge CLK);
      Fila = f; Dato = chars[0]; Escribir = 1'b1;
      prev_t = -1;
      for (int k = 0; k < n; k++) begin
        wait_lista(t);
        check("rs_done", LCD_RS, 1);
        if (prev_t >= 0) check("lista_spacing", t - prev_t, 2 + T_SETUP + T_EPW + T_EXEC);
        prev_t = t;
        if (k == n - 1) Escribir = 1'b0;
        else Dato = chars[k + 1];
      end
      repeat (2) @(negedge CLK);
      check("rs_fall", LCD_RS, 0);
      @(posedge CLK); #1;
      check("row_lista_count", lista_n, n);
      compare_writes($sformatf("row%0d", r));
      sync_clear();
      repeat (2) @(negedge CLK);
    end

    // Escribir held through power-up and init
    Fila = 1'b0; Dato = 8'h55;
    apply_reset(1'b1);
    wait_listo();
    #1;
    check("lista_before_init", lista_n, 0);
    wait_lista(t);
    Escribir = 1'b0;
    @(posedge CLK); #1;
    if (wr_t.size() == 8) begin
      check("addr_after_init", wr_t[6] > listo_t, 1);
      check("data_after_init", wr_t[7] > listo_t, 1);
    end
    check("lista_count_early", lista_n, 1);
    push_init();
    exp_q.push_back(9'h080);
    exp_q.push_back(9'h155);
    compare_writes("early");
    sync_clear();

    // Reset during E high of a data write
    @(negedge CLK);
    Fila = 1'($urandom_range(0, 1)); Dato = 8'($urandom_range(0, 255)); Escribir = 1'b1;
    wait_data_e(t_r);
    @(posedge CLK); #1;
    Reset = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("abort_e", LCD_E, 0);
    check("abort_rs", LCD_RS, 0);
    check("abort_db", LCD_DB, 0);
    check("abort_listo", Listo_Init, 0);
    check("abort_lista", Lista, 0);
    Escribir = 1'b0;
    @(posedge CLK); #1;
    Reset = 1'b0;
    wr_q.delete();
    wr_t.delete();
    lista_n = 0;
    wait_listo();
    @(posedge CLK); #1;
    check("reinit_lista", lista_n, 0);
    push_init();
    compare_writes("reinit");
    sync_clear();

    // Escribir dropped during EXEC; data 0x01 with RS=1 takes the short wait
    f = 1'($urandom_range(0, 1));
    @(negedge CLK);
    Fila = f; Dato = 8'h01; Escribir = 1'b1;
    wait_data_e(t_r);
    repeat (T_EPW + 1) @(negedge CLK);
    check("in_exec", LCD_E, 0);
    Escribir = 1'b0;
    wait_lista(t);
    check("lista_after_drop", t - t_r, T_EPW + T_EXEC);
    repeat (4) @(negedge CLK);
    f2 = 1'($urandom_range(0, 1));
    d2 = 8'($urandom_range(0, 255));
    Fila = f2; Dato = d2; Escribir = 1'b1;
    wait_lista(t);
    Escribir = 1'b0;
    repeat (3) @(posedge CLK); #1;
    check("lista_count_drop", lista_n, 2);
    exp_q.push_back(addr_of(f));
    exp_q.push_back(9'h101);
    exp_q.push_back(addr_of(f2));
    exp_q.push_back({1'b1, d2});
    compare_writes("drop");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
